// File: rtl/qsys_cpu_mul_pkg.sv
// Shared encodings for the iterative 32x32 multiply sequencer.
// Widths and latencies here assume the QSYS_CPU_MUL_HI_EN build for the high-word ops.
package qsys_cpu_mul_pkg;

  localparam logic [1:0] MUL_OP_MUL = 2'b00;
  localparam logic [1:0] MUL_OP_XUU = 2'b01;
  localparam logic [1:0] MUL_OP_XSU = 2'b10;
  localparam logic [1:0] MUL_OP_XSS = 2'b11;

  typedef enum logic [2:0] {
    MS_IDLE  = 3'd0,
    MS_ISSUE = 3'd1,
    MS_DRAIN = 3'd2,
    MS_CORR  = 3'd3,
    MS_DONE  = 3'd4
  } mul_state_e;

  // Plain constants mirroring the enum so the FSM register stays a bare vector.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_CORR  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] STEP_LL = 2'd0;
  localparam logic [1:0] STEP_LH = 2'd1;
  localparam logic [1:0] STEP_HL = 2'd2;
  localparam logic [1:0] STEP_HH = 2'd3;

  localparam int unsigned MUL_LAT_LO = 5;
  localparam int unsigned MUL_LAT_HI = 7;

  function automatic logic mul_is_hi(input logic [1:0] op);
    return op != MUL_OP_MUL;
  endfunction

endpackage

// File: rtl/qsys_cpu_cpu_mul16_cell.sv
// 16x16 unsigned multiplier with a single output register.
// Product of operands presented in cycle n is visible in cycle n+1.
module qsys_cpu_cpu_mul16_cell (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        ena,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      p <= '0;
    end else if (ena) begin
      p <= {16'b0, a} * {16'b0, b};
    end
  end

endmodule

// File: rtl/qsys_cpu_cpu_mul_seq.sv
// Iterative 32x32 multiply: four partial products through one 16x16 cell, accumulated over cycles.
// QSYS_CPU_MUL_HI_EN enables the high-word ops (MULXUU/MULXSU/MULXSS) and the 64-bit accumulator.
module qsys_cpu_cpu_mul_seq
  import qsys_cpu_mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_unsup
);

`ifdef QSYS_CPU_MUL_HI_EN
  localparam int ACC_W = 64;
`else
  localparam int ACC_W = 32;
`endif

  // Handshake: input transfers on in_valid & in_ready (IDLE only, never during flush);
  // output transfers on out_valid & out_ready, result held stable until then.
  logic [2:0]       state;
  logic [1:0]       step;
  logic [1:0]       land_step;
  logic             land_vld;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [1:0]       op_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] pp_ext;
  logic [ACC_W-1:0] pp_shift;
  logic [31:0]      result_q;
  logic             unsup_q;
  logic [15:0]      cell_a;
  logic [15:0]      cell_b;
  logic [31:0]      cell_p;
  logic             cell_ena;
  logic             cell_clr;
  logic             accept;
  logic             hi_op;
  logic [1:0]       last_step;

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  assign out_result = result_q;
  assign out_unsup  = unsup_q;
  assign accept     = in_valid & in_ready & ~flush;

`ifdef QSYS_CPU_MUL_HI_EN
  assign hi_op = mul_is_hi(op_q);
`else
  assign hi_op = 1'b0;
`endif
  assign last_step = hi_op ? STEP_HH : STEP_HL;

  always_comb begin
    cell_a = a_q[15:0];
    cell_b = b_q[15:0];
    case (step)
      STEP_LL: begin cell_a = a_q[15:0];  cell_b = b_q[15:0];  end
      STEP_LH: begin cell_a = a_q[15:0];  cell_b = b_q[31:16]; end
      STEP_HL: begin cell_a = a_q[31:16]; cell_b = b_q[15:0];  end
      default: begin cell_a = a_q[31:16]; cell_b = b_q[31:16]; end
    endcase
  end

  assign cell_ena = (state == ST_ISSUE);
  assign cell_clr = accept | (flush & ~in_ready);

  qsys_cpu_cpu_mul16_cell u_cell (
    .clk   (clk),
    .reset (reset),
    .clr   (cell_clr),
    .ena   (cell_ena),
    .a     (cell_a),
    .b     (cell_b),
    .p     (cell_p)
  );

  // Align the landing product by the step that produced it one cycle earlier.
  assign pp_ext = ACC_W'(cell_p);

  always_comb begin
    pp_shift = '0;
    case (land_step)
      STEP_LL: pp_shift = pp_ext;
      STEP_LH: pp_shift = pp_ext << 16;
      STEP_HL: pp_shift = pp_ext << 16;
`ifdef QSYS_CPU_MUL_HI_EN
      default: pp_shift = pp_ext << 32;
`else
      default: pp_shift = '0;
`endif
    endcase
  end

  assign acc_sum = acc + pp_shift;

`ifdef QSYS_CPU_MUL_HI_EN
  // Unsigned product high word adjusted for operands treated as negative.
  logic [31:0] sub_a;
  logic [31:0] sub_b;
  logic [31:0] corr_hi;

  always_comb begin
    sub_a   = (op_q[1] && a_q[31]) ? b_q : 32'd0;
    sub_b   = ((op_q == MUL_OP_XSS) && b_q[31]) ? a_q : 32'd0;
    corr_hi = acc[63:32] - sub_a - sub_b;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      step      <= STEP_LL;
      land_step <= STEP_LL;
      land_vld  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= MUL_OP_MUL;
      acc       <= '0;
      result_q  <= '0;
      unsup_q   <= 1'b0;
    end else begin
      land_vld <= 1'b0;
      if (land_vld) begin
        acc <= acc_sum;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q   <= in_src1;
            b_q   <= in_src2;
            op_q  <= in_op;
            acc   <= '0;
            step  <= STEP_LL;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          land_vld  <= 1'b1;
          land_step <= step;
          step      <= step + 2'd1;
          if (step == last_step) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
`ifdef QSYS_CPU_MUL_HI_EN
          if (hi_op) begin
            state <= ST_CORR;
          end else begin
            result_q <= acc_sum[31:0];
            unsup_q  <= 1'b0;
            state    <= ST_DONE;
          end
`else
          result_q <= (op_q == MUL_OP_MUL) ? acc_sum[31:0] : 32'd0;
          unsup_q  <= (op_q != MUL_OP_MUL);
          state    <= ST_DONE;
`endif
        end
        ST_CORR: begin
`ifdef QSYS_CPU_MUL_HI_EN
          acc[63:32] <= corr_hi;
          result_q   <= corr_hi;
          unsup_q    <= 1'b0;
          state      <= ST_DONE;
`else
          state <= ST_IDLE;
`endif
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Abandon overrides everything except the idle state; a DONE transfer still completes.
      if (flush && (state != ST_IDLE)) begin
        state    <= ST_IDLE;
        acc      <= '0;
        land_vld <= 1'b0;
        step     <= STEP_LL;
      end
    end
  end

endmodule

// File: tb/tb_qsys_cpu_cpu_mul_seq.sv
// Randomized and directed bench for qsys_cpu_cpu_mul_seq with a queue-based scoreboard.
// Expectations adapt to whether QSYS_CPU_MUL_HI_EN is defined for the build.
module tb_qsys_cpu_cpu_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_unsup;

  qsys_cpu_cpu_mul_seq dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_unsup  (out_unsup)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // expected entry: {latency[7:0], unsup, result[31:0]}
  logic [40:0] exp_q[$];
  int          acc_q[$];

  bit rand_rdy = 1'b0;
  always @(posedge clk) begin
    if (rand_rdy) begin
      #2 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [40:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    logic [63:0] p;
    logic [31:0] r;
    logic        u;
    logic [7:0]  lat;
    wa = {32'b0, a};
    wb = {32'b0, b};
    if (op[1]) wa = {{32{a[31]}}, a};
    if (op == 2'b11) wb = {{32{b[31]}}, b};
    p = wa * wb;
    if (op == 2'b00) begin
      r = p[31:0]; u = 1'b0; lat = 8'd5;
    end else begin
`ifdef QSYS_CPU_MUL_HI_EN
      r = p[63:32]; u = 1'b0; lat = 8'd7;
`else
      r = 32'd0; u = 1'b1; lat = 8'd5;
`endif
    end
    return {lat, u, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        holding = 1'b0;
  logic [31:0] held_r;
  logic        held_u;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (out_valid) begin
        check("in_ready_in_done", {31'b0, in_ready}, 32'd0);
        if (!holding) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_out_valid actual=1 expected=0 at cycle %0d", cyc);
          end else begin
            check("latency", cyc - acc_q[0], {24'b0, exp_q[0][40:33]});
            check("result", out_result, exp_q[0][31:0]);
            check("unsup", {31'b0, out_unsup}, {31'b0, exp_q[0][32]});
          end
          holding = 1'b1;
          held_r  = out_result;
          held_u  = out_unsup;
        end else begin
          check("hold_result", out_result, held_r);
          check("hold_unsup", {31'b0, out_unsup}, {31'b0, held_u});
        end
        if (out_ready) begin
          holding = 1'b0;
          if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end else if (holding) begin
        errors++;
        $display("FAIL valid_dropped actual=0 expected=1 at cycle %0d", cyc);
        holding = 1'b0;
      end
    end else begin
      holding = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL issue_timeout actual=busy expected=in_ready");
    end else begin
      exp_q.push_back(model(op, a, b));
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_src1 = '0; in_src2 = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle("reset");
    check("reset_result", out_result, 32'd0);
    check("reset_unsup", {31'b0, out_unsup}, 32'd0);

    // directed vectors
    issue(2'b00, 32'h0001_0002, 32'h0003_0004);
    wait_drain();
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b11, 32'h8000_0000, 32'h0000_0002);
    wait_drain();

    // consumer stall in DONE, then dead cycle and back-to-back accept
    out_ready = 1'b0;
    issue(2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
    end
    repeat (10) @(negedge clk);
    check("stall_valid_held", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_idle("after_handshake");
    issue(2'b00, 32'hDEAD_BEEF, 32'h0000_0010);
    wait_drain();

    // flush mid-operation
    issue(2'b01, 32'hFFFF_FFFF, 32'h1234_5678);
    @(posedge clk);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    check_idle("flush");
    repeat (10) @(negedge clk);
    issue(2'b00, 32'd3, 32'd5);
    wait_drain();

    // reset mid-operation
    issue(2'b01, 32'hFFFF_FFFF, 32'h1234_5678);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    check_idle("midreset");
    check("midreset_result", out_result, 32'd0);
    check("midreset_unsup", {31'b0, out_unsup}, 32'd0);
    repeat (10) @(negedge clk);
    issue(2'b00, 32'd3, 32'd5);
    wait_drain();

    // flush with in_valid while idle must not accept
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_op = 2'b00; in_src1 = 32'd7; in_src2 = 32'd9;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    check_idle("idle_flush");
    repeat (8) @(negedge clk);

    // randomized traffic with a randomly stalling consumer
    rand_rdy = 1'b1;
    repeat (80) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      issue(op, rnd_operand(), rnd_operand());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_drain();
    rand_rdy = 1'b0;
    #3 out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
